// File: rtl/synthesijer_shift_pipe.sv
// Pipelined barrel shifter: logical/arithmetic right, left and rotate right by b mod WIDTH.
// Latency: ceil(log2(WIDTH)/LEVELS_PER_STAGE) cycles from nd to valid, one op per cycle.
// No backpressure: stage-valid advances every cycle, result holds the last valid value.
module synthesijer_shift_pipe #(
    parameter int WIDTH            = 64,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             nd,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LATENCY = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;

    // Pipeline registers, one entry per stage.
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [SHAMT_W-1:0] amt_q  [LATENCY];
    logic [1:0]         mode_q [LATENCY];
    logic               sign_q [LATENCY];
    logic               vld_q  [LATENCY];

    // Combinational stage inputs and shifted outputs.
    logic [WIDTH-1:0]   in_data  [LATENCY];
    logic [SHAMT_W-1:0] in_amt   [LATENCY];
    logic [1:0]         in_mode  [LATENCY];
    logic               in_sign  [LATENCY];
    logic               in_vld   [LATENCY];
    logic [WIDTH-1:0]   nxt_data [LATENCY];

    logic unused_tail;

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_LSR: r = d >> sh;
            MODE_ASR: r = (d >> sh) | (sign ? ~({WIDTH{1'b1}} >> sh) : '0);
            MODE_LSL: r = d << sh;
            default:  r = (d >> sh) | (d << (WIDTH - sh));
        endcase
        return r;
    endfunction

    // Stage 0 sees the ports directly; the sign is captured here so later
    // arithmetic levels do not depend on already-shifted data.
    always_comb begin
        in_data[0] = a;
        in_amt[0]  = b[SHAMT_W-1:0];
        in_mode[0] = mode;
        in_sign[0] = a[WIDTH-1];
        in_vld[0]  = nd;
        for (int i = 1; i < LATENCY; i++) begin
            in_data[i] = data_q[i-1];
            in_amt[i]  = amt_q[i-1];
            in_mode[i] = mode_q[i-1];
            in_sign[i] = sign_q[i-1];
            in_vld[i]  = vld_q[i-1];
        end
    end

    always_comb begin
        logic [WIDTH-1:0]   d;
        logic [SHAMT_W-1:0] amt_bits;
        int                 k;
        d        = '0;
        amt_bits = '0;
        k        = 0;
        for (int i = 0; i < LATENCY; i++) begin
            d = in_data[i];
            for (int l = 0; l < LEVELS_PER_STAGE; l++) begin
                k        = i * LEVELS_PER_STAGE + l;
                // Levels past SHAMT_W shift out every amount bit, so they never fire.
                amt_bits = in_amt[i] >> k;
                if (amt_bits[0]) begin
                    d = shift_level(d, in_mode[i], in_sign[i], 1 << k);
                end
            end
            nxt_data[i] = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
                amt_q[i]  <= '0;
                mode_q[i] <= '0;
                sign_q[i] <= 1'b0;
                vld_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= in_vld[i];
                if (in_vld[i]) begin
                    data_q[i] <= nxt_data[i];
                    amt_q[i]  <= in_amt[i];
                    mode_q[i] <= in_mode[i];
                    sign_q[i] <= in_sign[i];
                end
            end
        end
    end

    assign result = data_q[LATENCY-1];
    assign valid  = vld_q[LATENCY-1];

    // Upper amount bits and the last stage's control fields have no consumer.
    assign unused_tail = ^{b[WIDTH-1:SHAMT_W], amt_q[LATENCY-1], mode_q[LATENCY-1], sign_q[LATENCY-1]};

endmodule
